ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
Instruction-fetch front end that sits directly downstream of the PC register in the IF stage. It takes the current word-address PC and issues in-order requests to instruction memory. It drives the PC register's PCWrite to advance the PC only when a request is accepted, and buffers {pc, instr} pairs in a small in-order queue that ID drains with a valid/ready handshake. Redirect flushes drop queued entries and discard late memory responses.

Parameters:
DEPTH, 4, number of queue entries (power of 2, ≥2); allocated-but-unfilled entries count as occupied.
DATA_W, 32, instruction width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
pc_i  in  [31:2]  current PC from the PC register (word address)
pc_write_o  out  1  to PCWrite; PC←NPC this edge
flush_i  in  1  redirect (branch/jump/exception); PC register loads its target separately
imem_req_o  out  1  fetch request
imem_addr_o  out  [31:2]  fetch word address (=pc_i)
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  in-order response valid, ≥1 cycle after grant
imem_rdata_i  in  DATA_W  response instruction
id_valid_o  out  1  head entry holds a filled instruction
id_ready_i  in  1  ID accepts head this cycle
id_instr_o  out  DATA_W  head instruction
id_pc_o  out  [31:2]  head PC

Behaviour:
- Reset (sync, high): queue empty, head/tail pointers 0, occ=0, drop_cnt=0. While reset is high: imem_req_o=0, pc_write_o=0, id_valid_o=0, id_instr_o=0, id_pc_o=0.
- Entry: {pc, instr, filled}. occ = allocated entries, range 0..DEPTH. Counter width $clog2(DEPTH+1).
- Issue (combinational): imem_req_o = !reset && !flush_i && occ<DEPTH && drop_cnt==0. imem_addr_o=pc_i.
- pc_write_o = imem_req_o && imem_gnt_i. No PC advance without a grant.
- On grant: allocate the tail entry with pc=pc_i and filled=0, then tail++ (mod DEPTH).
- On imem_rvalid_i:
  - If drop_cnt>0: discard the response, drop_cnt--.
  - Otherwise: write imem_rdata_i into the oldest unfilled entry and set filled=1. That entry is tracked by a fill pointer.
  - If rvalid arrives with no unfilled entry and drop_cnt==0: protocol error. Ignore it and fire an assertion.
- Output: id_valid_o = occ>0 && head.filled. id_instr_o/id_pc_o come from the head entry and are 0 when id_valid_o=0.
  - No bypass: a response at cycle N gives id_valid_o=1 at N+1 at the earliest.
  - Latency: grant at cycle G → id_valid_o at G+2 minimum.
- Pop: id_valid_o && id_ready_i → head++, occ--.
  - Same-cycle pop + grant: occ unchanged.
  - A full queue with a same-cycle pop still does not issue, because issue depends on registered occ.
- Flush (flush_i=1): no request that cycle.
  - Next cycle: queue empty, all pointers 0, occ=0.
  - drop_cnt = (allocated-unfilled count) − (1 if rvalid this cycle and the response would fill an entry).
  - A same-cycle rvalid is discarded, and any pop that cycle is ignored.
  - Issue resumes once drop_cnt==0, using the redirected pc_i.
- Flush during reset: reset dominates.
- Wrap-around: all pointers wrap mod DEPTH. Full is occ==DEPTH, not pointer equality.
- Stall: id_ready_i=0 holds the head entry and all outputs stable. Issue continues until occ==DEPTH.

Decomposition:
- Shared package ifu_pkg holds:
  - fetch_entry_t struct {logic[31:2] pc; logic[DATA_W-1:0] instr; logic filled;}
  - the START_ADDR constant (30'h0000BFF), shared with the PC register
  - NOP encoding, 32'h0
- No sub-module needed. Entry storage, three pointers, occ and drop_cnt all live in one always_ff block.

Test Plan:
1. Reset, then pc_i=0xBFF, gnt=1, rvalid one cycle after each grant with rdata=0x20080005 → pc_write_o=1 on the first grant; id_valid_o=1 two cycles later with id_pc_o=0xBFF and id_instr_o=0x20080005.
2. id_ready_i=0 with continuous grants → exactly 4 grants and 4 pc_write_o pulses, then imem_req_o=0. Raising id_ready_i drains the entries in order 0xBFF,0xC00,0xC01,0xC02.
3. Two grants outstanding and flush_i=1 (no same-cycle rvalid) → drop_cnt=2 and id_valid_o=0. The next two rvalids are discarded. The first request after them uses the new pc_i=0x100.
4. Flush coinciding with rvalid while one entry is unfilled → drop_cnt=0. Issue resumes the cycle after the flush.
5. Full queue (occ=4) with id_ready_i=1 and gnt=1 → first a pop-only cycle, then steady state with one pop + one grant per cycle and occ held at 3–4. Pointers wrap after 4 entries with no loss or duplication.
6. reset asserted while 2 requests are in flight → all outputs 0 on the next edge. Stray rvalids after reset are ignored without corrupting the queue; pc_i=0xBFF is refetched.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: IF-stage types and constants shared by the PC register and the fetch queue.
package ifu_pkg;
    localparam int INSTR_W = 32;
    localparam logic [31:2] START_ADDR = 30'h0000BFF;
    localparam logic [31:0] NOP = 32'h0;
    typedef struct packed {
        logic [31:2]        pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } fetch_entry_t;
endpackage

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: issues in-order imem requests from the PC and buffers {pc, instr} for ID.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:2]       pc_i,
    output logic              pc_write_o,
    input  logic              flush_i,
    output logic              imem_req_o,
    output logic [31:2]       imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [DATA_W-1:0] id_instr_o,
    output logic [31:2]       id_pc_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = INSTR_W;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  head;
    logic [PW-1:0] head_q, tail_q, fill_q;
    logic [CW-1:0] occ_q, occ_d, pend_q, pend_d, drop_q, drop_d;
    logic          grant, fill, drop, pop;

    assign head        = mem_q[head_q];
    assign imem_req_o  = !reset && !flush_i && occ_q < CW'(DEPTH) && drop_q == '0;
    assign imem_addr_o = pc_i;
    assign pc_write_o  = imem_req_o && imem_gnt_i;
    assign grant       = pc_write_o;
    assign drop        = imem_rvalid_i && drop_q != '0;
    assign fill        = imem_rvalid_i && drop_q == '0 && pend_q != '0;
    assign id_valid_o  = !reset && occ_q != '0 && head.filled;
    assign pop         = id_valid_o && id_ready_i;
    assign id_instr_o  = id_valid_o ? DATA_W'(head.instr) : DATA_W'(NOP);
    assign id_pc_o     = id_valid_o ? head.pc : '0;

    // On a flush every still-unfilled request becomes a response to throw away.
    assign occ_d  = flush_i ? '0 : occ_q + CW'(grant) - CW'(pop);
    assign pend_d = flush_i ? '0 : pend_q + CW'(grant) - CW'(fill);
    assign drop_d = drop_q - CW'(drop) + (flush_i ? pend_q - CW'(fill) : '0);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
            if (reset)
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (grant) begin
                mem_q[tail_q] <= '{pc: pc_i, instr: '0, filled: 1'b0};
                tail_q        <= tail_q + PW'(1);
            end
            if (fill) begin
                mem_q[fill_q].instr  <= IW'(imem_rdata_i);
                mem_q[fill_q].filled <= 1'b1;
                fill_q               <= fill_q + PW'(1);
            end
            if (pop) head_q <= head_q + PW'(1);
        end
        occ_q  <= reset ? '0 : occ_d;
        pend_q <= reset ? '0 : pend_d;
        drop_q <= reset ? '0 : drop_d;
    end

    rvalid_without_entry_a: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid_i && drop_q == '0 |-> pend_q != '0);
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb_ifu_fetch_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_ifu_fetch_queue;
    import ifu_pkg::*;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, reset, flush_i, imem_gnt_i, imem_rvalid_i, id_ready_i;
    logic [31:2] pc_i, imem_addr_o, id_pc_o;
    logic [31:0] imem_rdata_i, id_instr_o;
    logic        pc_write_o, imem_req_o, id_valid_o;

    ifu_fetch_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .pc_write_o(pc_write_o), .flush_i(flush_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .id_valid_o(id_valid_o),
        .id_ready_i(id_ready_i), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:2] pc; logic [31:0] ins; bit f; } m_t;
    typedef struct { logic [31:0] d; int r; } p_t;
    m_t          mq[$];
    p_t          pq[$];
    int          drop_m, cyc, last_r, lat = 1, rv_pct = 100;
    int          checks, errors, pw_seen, g_cyc = -1, v_cyc = -1;
    bit          fix_data = 1;
    logic [31:2] pc_m = START_ADDR, v_pc;
    logic [31:0] v_ins;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle(input bit rst, input bit fl, input logic [31:2] tgt, input bit gnt, input bit rdy);
        bit rv, e_req, e_pw, e_val, wf;
        logic [31:0] rd, e_ins;
        logic [31:2] e_pc;
        int unf;
        rv = !rst && pq.size() > 0 && pq[0].r <= cyc && $urandom_range(99) < rv_pct;
        rd = rv ? pq[0].d : $urandom;
        reset = rst; flush_i = fl; imem_gnt_i = gnt; id_ready_i = rdy;
        imem_rvalid_i = rv; imem_rdata_i = rd; pc_i = pc_m;
        e_req = !rst && !fl && mq.size() < DEPTH && drop_m == 0;
        e_pw  = e_req && gnt;
        e_val = 0; e_pc = '0; e_ins = '0;
        if (!rst && mq.size() > 0 && mq[0].f) begin
            e_val = 1; e_pc = mq[0].pc; e_ins = mq[0].ins;
        end
        @(negedge clk);
        check("req", imem_req_o, e_req);
        check("pc_write", pc_write_o, e_pw);
        check("id_valid", id_valid_o, e_val);
        check("id_pc", id_pc_o, e_pc);
        check("id_instr", id_instr_o, e_ins);
        if (e_req) check("addr", imem_addr_o, pc_m);
        pw_seen += int'(pc_write_o);
        if (g_cyc < 0 && pc_write_o) g_cyc = cyc;
        if (v_cyc < 0 && id_valid_o) begin v_cyc = cyc; v_pc = id_pc_o; v_ins = id_instr_o; end
        @(posedge clk);
        if (rst) begin
            mq.delete(); pq.delete(); drop_m = 0; pc_m = START_ADDR;
        end else begin
            if (rv) void'(pq.pop_front());
            if (fl) begin
                unf = 0;
                foreach (mq[i]) if (!mq[i].f) unf++;
                wf = rv && drop_m == 0 && unf > 0;
                drop_m = drop_m - int'(rv && drop_m > 0) + unf - int'(wf);
                mq.delete();
                pc_m = tgt;
            end else begin
                if (rv && drop_m > 0) drop_m--;
                else if (rv)
                    for (int i = 0; i < mq.size(); i++)
                        if (!mq[i].f) begin mq[i].ins = rd; mq[i].f = 1; break; end
                if (e_val && rdy) void'(mq.pop_front());
                if (e_pw) begin
                    mq.push_back('{pc_m, 32'h0, 1'b0});
                    last_r = (cyc + lat > last_r) ? cyc + lat : last_r + 1;
                    pq.push_back('{fix_data ? 32'h20080005 : $urandom, last_r});
                    pc_m++;
                end
            end
        end
        #1;
        cyc++;
    endtask

    task automatic run(input int n, input bit gnt, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, gnt, rdy);
    endtask

    initial begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, 1, 1);
        pw_seen = 0;
        run(8, 1, 0);
        check("t2_grants", pw_seen, 4);
        check("t1_latency", v_cyc - g_cyc, 2);
        check("t1_pc", v_pc, START_ADDR);
        check("t1_instr", v_ins, 32'h20080005);
        run(6, 0, 1);
        lat = 3;
        run(2, 1, 1);
        cycle(0, 1, 30'h100, 0, 1);
        run(8, 1, 1);
        run(4, 0, 1);
        lat = 1;
        run(1, 1, 0);
        cycle(0, 1, 30'h200, 0, 0);
        run(4, 1, 1);
        run(6, 1, 0);
        run(12, 1, 1);
        lat = 3;
        run(2, 1, 1);
        cycle(1, 0, '0, 1, 1);
        run(8, 1, 1);
        fix_data = 0; rv_pct = 75;
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 3);
            cycle($urandom_range(299) == 0, $urandom_range(24) == 0, 30'($urandom),
                  $urandom_range(3) != 0, $urandom_range(2) != 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
